gemm_instr_fifo: RTL and testbench

- Buffers GEMM instruction packets produced by the GEMM functional unit; sits directly downstream of it and upstream of the systolic-array/scratchpad controller.
- Each entry holds one `instrFIFO_t` word: `{new_weight, rd, rs3, rs2, rs1}`.
- Decouples issue rate from array occupancy.
- First-word-fall-through read side with a valid/ready handshake; sticky overflow flag for bring-up debug.

---
 rtl/gemm_instr_fifo_if.sv | 28 ++
 rtl/gemm_instr_fifo.sv | 75 +++++++
 tb/tb_gemm_instr_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/gemm_instr_fifo_if.sv
// Handshake bundle between the GEMM FU (master) and the instruction FIFO (slave).
interface gemm_instr_fifo_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ENTRY_W = 17
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               push;
    logic [ENTRY_W-1:0] push_data;
    logic               flush;
    logic               out_ready;
    logic               out_valid;
    logic [ENTRY_W-1:0] out_data;
    logic               full;
    logic               almost_full;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    modport master (
        output push, push_data, flush, out_ready,
        input  out_valid, out_data, full, almost_full, count, overflow
    );

    modport slave (
        input  push, push_data, flush, out_ready,
        output out_valid, out_data, full, almost_full, count, overflow
    );
endinterface

// File: rtl/gemm_instr_fifo.sv
// GEMM instruction FIFO: first-word-fall-through buffer of {new_weight, rd, rs3, rs2, rs1}
// packets between the GEMM FU and the systolic-array controller, with sticky overflow.
module gemm_instr_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAT_W    = 4,
    parameter int unsigned ENTRY_W  = 1 + 4 * MAT_W,
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input  logic             CLK,
    input  logic             RST,
    gemm_instr_fifo_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;

    logic full_c;
    logic pop_fire_c;
    logic push_ok_c;

    // Handshake qualifiers; all derived from registered count, so out_ready never reaches full/count.
    always_comb begin
        full_c     = (count_q == CNT_W'(DEPTH));
        pop_fire_c = (count_q != '0) & bus.out_ready;
        push_ok_c  = bus.push & (~full_c | pop_fire_c);
    end

    // Storage, pointers, occupancy and sticky overflow; flush outranks push and pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok_c) begin
                mem_q[wptr_q] <= bus.push_data;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_fire_c) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (bus.push && !push_ok_c) begin
                overflow_q <= 1'b1;
            end
            case ({push_ok_c, pop_fire_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head of queue falls through; status flags decode the count register.
    always_comb begin
        bus.out_valid   = (count_q != '0);
        bus.out_data    = mem_q[rptr_q];
        bus.full        = full_c;
        bus.almost_full = (count_q >= CNT_W'(AF_LEVEL));
        bus.count       = count_q;
        bus.overflow    = overflow_q;
    end
endmodule

// File: tb/tb_gemm_instr_fifo.sv
// Self-checking bench for gemm_instr_fifo: directed table, corner sequences, random vs queue model.
module tb_gemm_instr_fifo;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ENTRY_W = 17;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    gemm_instr_fifo_if #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) bus ();

    gemm_instr_fifo #(.DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic               push;
        logic [ENTRY_W-1:0] data;
        logic               flush;
        logic               ready;
        logic [3:0]         e_cnt;
        logic               e_valid;
        logic [ENTRY_W-1:0] e_data;
        logic               e_full;
        logic               e_af;
        logic               e_ovf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [ENTRY_W-1:0] mq[$];
    logic               m_ovf;

    vec_t tbl[17];

    function automatic vec_t mk(logic p, logic [ENTRY_W-1:0] d, logic f, logic r,
                                int cnt, logic v, logic [ENTRY_W-1:0] ed,
                                logic fl, logic af, logic ov);
        vec_t x;
        x.push = p;  x.data = d;  x.flush = f;  x.ready = r;
        x.e_cnt = 4'(cnt); x.e_valid = v; x.e_data = ed;
        x.e_full = fl; x.e_af = af; x.e_ovf = ov;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the reference model, sample 1 time unit after the edge.
    task automatic drive(logic p, logic [ENTRY_W-1:0] d, logic f, logic r);
        logic popf, acc;
        bus.push = p; bus.push_data = d; bus.flush = f; bus.out_ready = r;
        if (f) begin
            mq.delete();
        end else begin
            popf = (mq.size() != 0) && r;
            acc  = p && ((mq.size() < DEPTH) || popf);
            if (p && !acc) m_ovf = 1'b1;
            if (popf) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        @(posedge CLK);
        #1;
        bus.push = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic check_model(string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, 32'(bus.count), 32'(sz));
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(sz != 0));
        if (sz != 0) chk({tag, ".data"}, 32'(bus.out_data), 32'(mq[0]));
        chk({tag, ".full"}, 32'(bus.full), 32'(sz == DEPTH));
        chk({tag, ".afull"}, 32'(bus.almost_full), 32'(sz >= DEPTH - 2));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int rem;
        bus.push = 1'b0; bus.push_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        m_ovf = 1'b0;

        // Fill 8, overflow push, drain 8; expectations written out from the FIFO rules.
        for (int k = 1; k <= 8; k++)
            tbl[k-1] = mk(1'b1, ENTRY_W'(k), 1'b0, 1'b0, k, 1'b1, 17'h00001, k == 8, k >= 6, 1'b0);
        tbl[8] = mk(1'b1, 17'h1ABCD, 1'b0, 1'b0, 8, 1'b1, 17'h00001, 1'b1, 1'b1, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            rem = 8 - j;
            tbl[8+j] = mk(1'b0, '0, 1'b0, 1'b1, rem, rem != 0, ENTRY_W'(j + 1), 1'b0, rem >= 6, 1'b1);
        end

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst.count", 32'(bus.count), 0);
        chk("rst.valid", 32'(bus.out_valid), 0);
        chk("rst.data", 32'(bus.out_data), 0);
        chk("rst.full", 32'(bus.full), 0);
        chk("rst.afull", 32'(bus.almost_full), 0);
        chk("rst.ovf", 32'(bus.overflow), 0);

        foreach (tbl[i]) begin
            drive(tbl[i].push, tbl[i].data, tbl[i].flush, tbl[i].ready);
            chk($sformatf("tbl%0d.count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d.data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d.full", i), 32'(bus.full), 32'(tbl[i].e_full));
            chk($sformatf("tbl%0d.afull", i), 32'(bus.almost_full), 32'(tbl[i].e_af));
            chk($sformatf("tbl%0d.ovf", i), 32'(bus.overflow), 32'(tbl[i].e_ovf));
        end

        // Async reset with 3 entries loaded: visible before any clock edge.
        for (int k = 0; k < 3; k++) drive(1'b1, ENTRY_W'(k + 32'h50), 1'b0, 1'b0);
        check_model("pre_rst");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("arst.count", 32'(bus.count), 0);
        chk("arst.valid", 32'(bus.out_valid), 0);
        chk("arst.full", 32'(bus.full), 0);
        chk("arst.ovf", 32'(bus.overflow), 0);
        mq.delete();
        m_ovf = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Push at full with simultaneous pop: accepted, no overflow, emerges as 8th pop.
        for (int k = 1; k <= 8; k++) drive(1'b1, ENTRY_W'(k), 1'b0, 1'b0);
        drive(1'b1, 17'h10F0F, 1'b0, 1'b1);
        chk("simul.count", 32'(bus.count), 8);
        chk("simul.ovf", 32'(bus.overflow), 0);
        for (int j = 0; j < 8; j++) begin
            if (j == 7) chk("simul.last", 32'(bus.out_data), 32'h10F0F);
            else chk("simul.order", 32'(bus.out_data), 32'(j + 2));
            drive(1'b0, '0, 1'b0, 1'b1);
        end
        check_model("simul.drained");

        // Empty FIFO, push with ready: no same-cycle pop, head visible next cycle.
        drive(1'b1, 17'h12345, 1'b0, 1'b1);
        chk("empty.count", 32'(bus.count), 1);
        chk("empty.valid", 32'(bus.out_valid), 1);
        chk("empty.data", 32'(bus.out_data), 32'h12345);
        drive(1'b0, '0, 1'b0, 1'b1);
        check_model("empty.pop");

        // Flush beats push and pop, then pointer wrap with streaming traffic.
        for (int k = 0; k < 5; k++) drive(1'b1, ENTRY_W'(32'h200 + k), 1'b0, 1'b0);
        drive(1'b1, 17'h1DEAD, 1'b1, 1'b1);
        chk("flush.count", 32'(bus.count), 0);
        chk("flush.valid", 32'(bus.out_valid), 0);
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, ENTRY_W'(32'h300 + k), 1'b0, k >= 3);
            check_model("wrap");
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            check_model("wrap.drain");
        end

        // Random traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 99) < 60, ENTRY_W'($urandom),
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 45);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
